// File: rtl/core_sequencer_if.sv
// Memory handshake bundle between the sequencer (master) and the instruction/data memories (slave).
interface core_sequencer_if;
  logic out_imem_req;
  logic in_imem_ack;
  logic out_dmem_req;
  logic out_dmem_we;
  logic in_dmem_ack;

  modport master (
    output out_imem_req,
    output out_dmem_req,
    output out_dmem_we,
    input  in_imem_ack,
    input  in_dmem_ack
  );

  modport slave (
    input  out_imem_req,
    input  out_dmem_req,
    input  out_dmem_we,
    output in_imem_ack,
    output in_dmem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV64IF control FSM: fetch/decode/exec/mem/writeback with memory handshakes,
// FPU stretch, memory-wait timeout and retired-instruction counter.
module core_sequencer #(
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned FPU_LAT  = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  core_sequencer_if.master        mem_if,
  input  logic                    in_start,
  input  logic [6:0]              in_opcode,
  input  logic                    in_fp_multi,
  output logic                    out_ir_we,
  output logic                    out_pc_we,
  output logic                    out_int_rf_we_en,
  output logic                    out_fp_rf_we_en,
  output logic [2:0]              out_state,
  output logic                    out_busy,
  output logic                    out_trap,
  output logic [63:0]             out_instret
);

  localparam int unsigned EXEC_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [EXEC_W-1:0] EXEC_MULTI = EXEC_W'((FPU_LAT > 0) ? FPU_LAT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef struct packed {
    logic mem;
    logic store;
    logic int_we;
    logic fp_we;
  } op_cls_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [EXEC_W-1:0]   exec_q, exec_d;
  op_cls_t             cls_q, cls_d;
  logic [63:0]         instret_q, instret_d;

  op_cls_t dec_cls;
  logic    dec_exec;
  logic    dec_halt;
  logic    dec_opfp;
  logic    timeout_hit;

  always_comb begin
    dec_cls  = '0;
    dec_exec = 1'b0;
    dec_halt = 1'b0;
    dec_opfp = 1'b0;
    unique case (in_opcode)
      7'b0000011: begin dec_exec = 1'b1; dec_cls.mem = 1'b1; dec_cls.int_we = 1'b1; end
      7'b0000111: begin dec_exec = 1'b1; dec_cls.mem = 1'b1; dec_cls.fp_we = 1'b1; end
      7'b0100011,
      7'b0100111: begin dec_exec = 1'b1; dec_cls.mem = 1'b1; dec_cls.store = 1'b1; end
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
                  begin dec_exec = 1'b1; dec_cls.int_we = 1'b1; end
      7'b1100011: dec_exec = 1'b1;
      7'b1010011: begin
        dec_exec       = 1'b1;
        dec_opfp       = 1'b1;
        dec_cls.int_we = 1'b1;
        dec_cls.fp_we  = 1'b1;
      end
      7'b1110011: dec_halt = 1'b1;
      default:    ;
    endcase
  end

  // A zero MAX_WAIT disables the timeout; an ack on the final cycle is checked first and wins.
  assign timeout_hit = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    exec_d    = exec_q;
    cls_d     = cls_q;
    instret_d = instret_q;

    mem_if.out_imem_req = 1'b0;
    mem_if.out_dmem_req = 1'b0;
    mem_if.out_dmem_we  = 1'b0;
    out_ir_we           = 1'b0;
    out_pc_we           = 1'b0;
    out_int_rf_we_en    = 1'b0;
    out_fp_rf_we_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        mem_if.out_imem_req = 1'b1;
        if (mem_if.in_imem_ack) begin
          out_ir_we = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (!dec_exec) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
          exec_d  = (dec_opfp && in_fp_multi) ? EXEC_MULTI : '0;
        end
      end
      S_EXEC: begin
        if (exec_q != '0) begin
          exec_d = exec_q - 1'b1;
        end else if (cls_q.mem) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_if.out_dmem_req = 1'b1;
        mem_if.out_dmem_we  = cls_q.store;
        if (mem_if.in_dmem_ack) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        out_pc_we        = 1'b1;
        out_int_rf_we_en = cls_q.int_we;
        out_fp_rf_we_en  = cls_q.fp_we;
        instret_d        = instret_q + 64'd1;
        state_d          = S_FETCH;
        wait_d           = '0;
      end
      S_HALT: begin
        // Resuming from HALT retires the SYSTEM instruction and advances the PC.
        if (in_start) begin
          out_pc_we = 1'b1;
          instret_d = instret_q + 64'd1;
          state_d   = S_FETCH;
          wait_d    = '0;
        end
      end
      S_TRAP: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      exec_q    <= '0;
      cls_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      exec_q    <= exec_d;
      cls_q     <= cls_d;
      instret_q <= instret_d;
    end
  end

  assign out_state   = state_q;
  assign out_busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)   || (state_q == S_WB);
  assign out_trap    = (state_q == S_TRAP);
  assign out_instret = instret_q;

endmodule
